// File: rtl/ifmap_radr_pkg.sv
// Shared definitions for the ifmap bank read-address generator.
// Holds the default configuration field width, the field count and the
// position of each field inside config_data (field 0 sits in the MSBs).
// It also holds a packed view of the configuration and the FSM state type.
package ifmap_radr_pkg;

    localparam int CFG_WIDTH_DEFAULT = 8;
    localparam int NUM_CFG_FIELDS    = 9;

    // Field order inside config_data, most significant field first
    localparam int FLD_OX0    = 0;
    localparam int FLD_OY0    = 1;
    localparam int FLD_FX     = 2;
    localparam int FLD_FY     = 3;
    localparam int FLD_STRIDE = 4;
    localparam int FLD_IX0    = 5;
    localparam int FLD_IY0    = 6;
    localparam int FLD_IC1    = 7;
    localparam int FLD_PAD    = 8;

    // Packed view of config_data; the first member lands in the MSBs
    typedef struct packed {
        logic [CFG_WIDTH_DEFAULT-1:0] ox0;
        logic [CFG_WIDTH_DEFAULT-1:0] oy0;
        logic [CFG_WIDTH_DEFAULT-1:0] fx;
        logic [CFG_WIDTH_DEFAULT-1:0] fy;
        logic [CFG_WIDTH_DEFAULT-1:0] stride;
        logic [CFG_WIDTH_DEFAULT-1:0] ix0;
        logic [CFG_WIDTH_DEFAULT-1:0] iy0;
        logic [CFG_WIDTH_DEFAULT-1:0] ic1;
        logic [CFG_WIDTH_DEFAULT-1:0] pad;
    } cfg_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/radr_loop_counter.sv
// One level of the tile loop nest.
// The counter counts 0..bound-1 and advances when carry_in is set. It wraps
// to 0 after bound-1 and raises carry_out in that cycle, so the next outer
// level can advance.
// Ports: clk, rst_n (async, active-low), clear (synchronous restart to 0),
//        carry_in (advance enable), bound, count_next (value the counter
//        takes at the next edge), carry_out (wrap this cycle).
module radr_loop_counter
    import ifmap_radr_pkg::*;
#(
    parameter int WIDTH = CFG_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] bound,
    output logic [WIDTH-1:0] count_next,
    output logic             carry_out
);

    logic [WIDTH-1:0] count;
    logic             at_last;

    assign at_last   = (count == bound - WIDTH'(1));
    assign carry_out = carry_in && at_last;

    // The next value is exported so that the parent can register an address
    // for the element the counter is about to point at.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (carry_in) begin
            count_next = at_last ? '0 : count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/ifmap_tile_radr_gen.sv
// Read-address generator for the ifmap double-buffer bank.
// It walks one tile in the order ox (innermost), oy, fx, fy, ic1 (outermost).
// It emits one registered bank address per valid/ready handshake.
// Address: ic1*IX0*IY0 + iy*IX0 + ix, where ix = ox*STRIDE + fx - PAD and
// iy = oy*STRIDE + fy - PAD. The address is built from running offsets, so
// the address path has no multiplier.
// Ports: clk, rst_n (async, active-low)
//        config_en/config_data  configuration load, honoured only in IDLE
//        start                  begin a tile walk, honoured only in IDLE
//        adr_valid/adr_ready    output handshake
//        adr, adr_pad           address, and a flag for the zero-padding region
//        busy                   walk in progress
//        done                   one-cycle pulse after the last handshake
// Build option: define IFMAP_RADR_PAD_EN to honour the PAD field. Otherwise
// PAD is ignored and adr_pad stays 0.
module ifmap_tile_radr_gen #(
    parameter int BANK_ADDR_WIDTH = 8,
    parameter int CFG_WIDTH       = ifmap_radr_pkg::CFG_WIDTH_DEFAULT,
    parameter int NUM_CFG_FIELDS  = ifmap_radr_pkg::NUM_CFG_FIELDS
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                config_en,
    input  logic [CFG_WIDTH*NUM_CFG_FIELDS-1:0] config_data,
    input  logic                                start,
    output logic                                adr_valid,
    input  logic                                adr_ready,
    output logic [BANK_ADDR_WIDTH-1:0]          adr,
    output logic                                adr_pad,
    output logic                                busy,
    output logic                                done
);

    import ifmap_radr_pkg::*;

    localparam int AW = BANK_ADDR_WIDTH;
    localparam int CW = CFG_WIDTH;
    localparam int PW = CFG_WIDTH + 2;
    localparam int SW = (AW > PW) ? AW : PW;

    state_t state, next_state;

    logic [CW*NUM_CFG_FIELDS-1:0] cfg_q;
    logic [CW-1:0] ox0, oy0, fx, fy, stride, ix0, iy0, ic1, pad;

    logic [SW-1:0] ox_s, oy_s, nxt_ox_s, nxt_oy_s;
    logic [AW-1:0] oy_row, fy_row, chan, nxt_oy_row, nxt_fy_row, nxt_chan;
    logic [AW-1:0] plane, row_step, pad_off, adr_calc;
    logic [CW-1:0] ox_nxt, oy_nxt, fx_nxt, fy_nxt, ic1_nxt;
    logic          c_ox, c_oy, c_fx, c_fy, c_ic1;
    logic          bounds_ok, start_go, zero_job, adv, last_hs, pad_calc;
    logic          unused_counts;

    assign ox0    = cfg_q[(NUM_CFG_FIELDS-1-FLD_OX0)*CW    +: CW];
    assign oy0    = cfg_q[(NUM_CFG_FIELDS-1-FLD_OY0)*CW    +: CW];
    assign fx     = cfg_q[(NUM_CFG_FIELDS-1-FLD_FX)*CW     +: CW];
    assign fy     = cfg_q[(NUM_CFG_FIELDS-1-FLD_FY)*CW     +: CW];
    assign stride = cfg_q[(NUM_CFG_FIELDS-1-FLD_STRIDE)*CW +: CW];
    assign ix0    = cfg_q[(NUM_CFG_FIELDS-1-FLD_IX0)*CW    +: CW];
    assign iy0    = cfg_q[(NUM_CFG_FIELDS-1-FLD_IY0)*CW    +: CW];
    assign ic1    = cfg_q[(NUM_CFG_FIELDS-1-FLD_IC1)*CW    +: CW];
    assign pad    = cfg_q[(NUM_CFG_FIELDS-1-FLD_PAD)*CW    +: CW];

    assign bounds_ok = (|ox0) && (|oy0) && (|fx) && (|fy) && (|ic1);
    assign start_go  = (state == IDLE) && start && bounds_ok;
    assign zero_job  = (state == IDLE) && start && !bounds_ok;
    assign adr_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign adv       = adr_valid && adr_ready;
    // ox advances only on a handshake, so a carry out of ic1 marks the
    // handshake of the last element.
    assign last_hs   = c_ic1;

    radr_loop_counter #(.WIDTH(CW)) u_ox (
        .clk(clk), .rst_n(rst_n), .clear(start_go), .carry_in(adv),
        .bound(ox0), .count_next(ox_nxt), .carry_out(c_ox));
    radr_loop_counter #(.WIDTH(CW)) u_oy (
        .clk(clk), .rst_n(rst_n), .clear(start_go), .carry_in(c_ox),
        .bound(oy0), .count_next(oy_nxt), .carry_out(c_oy));
    radr_loop_counter #(.WIDTH(CW)) u_fx (
        .clk(clk), .rst_n(rst_n), .clear(start_go), .carry_in(c_oy),
        .bound(fx), .count_next(fx_nxt), .carry_out(c_fx));
    radr_loop_counter #(.WIDTH(CW)) u_fy (
        .clk(clk), .rst_n(rst_n), .clear(start_go), .carry_in(c_fx),
        .bound(fy), .count_next(fy_nxt), .carry_out(c_fy));
    radr_loop_counter #(.WIDTH(CW)) u_ic1 (
        .clk(clk), .rst_n(rst_n), .clear(start_go), .carry_in(c_fy),
        .bound(ic1), .count_next(ic1_nxt), .carry_out(c_ic1));

    // The ox, oy and ic1 positions are carried by the running offsets.
    // fy_nxt is needed only by the pad check.
    assign unused_counts = ^{ox_nxt, oy_nxt, ic1_nxt, fy_nxt};

    // Running offsets for the element the counters are about to point at.
    // A level that wraps returns to 0. Every inner offset that wraps in the
    // same handshake falls back to the new outer base.
    always_comb begin
        nxt_ox_s   = ox_s;
        nxt_oy_s   = oy_s;
        nxt_oy_row = oy_row;
        nxt_fy_row = fy_row;
        nxt_chan   = chan;
        if (start_go) begin
            nxt_ox_s   = '0;
            nxt_oy_s   = '0;
            nxt_oy_row = '0;
            nxt_fy_row = '0;
            nxt_chan   = '0;
        end else if (adv) begin
            nxt_ox_s = c_ox ? '0 : ox_s + SW'(stride);
            if (c_ox) begin
                nxt_oy_s   = c_oy ? '0 : oy_s + SW'(stride);
                nxt_oy_row = c_oy ? '0 : oy_row + row_step;
            end
            if (c_fx) begin
                nxt_fy_row = c_fy ? '0 : fy_row + AW'(ix0);
            end
            if (c_fy) begin
                nxt_chan = c_ic1 ? '0 : chan + plane;
            end
        end
    end

    assign adr_calc = nxt_chan + nxt_oy_row + nxt_fy_row + AW'(nxt_ox_s)
                    + AW'(fx_nxt) - pad_off;

`ifdef IFMAP_RADR_PAD_EN
    logic [PW-1:0] ix_off, iy_off;

    // A set sign bit means the element lies before the first column or row.
    // Otherwise it is compared against the ifmap extent.
    assign ix_off   = PW'(nxt_ox_s) + PW'(fx_nxt) - PW'(pad);
    assign iy_off   = PW'(nxt_oy_s) + PW'(fy_nxt) - PW'(pad);
    assign pad_calc = ix_off[PW-1] || (ix_off >= PW'(ix0))
                   || iy_off[PW-1] || (iy_off >= PW'(iy0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_off <= '0;
        end else if (start_go) begin
            pad_off <= AW'(pad) * AW'(ix0) + AW'(pad);
        end
    end
`else
    logic unused_pad;

    assign unused_pad = ^{pad, nxt_oy_s};
    assign pad_calc   = 1'b0;
    assign pad_off    = '0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start_go) next_state = RUN;
            RUN:  if (last_hs)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Configuration, pitches, running offsets and the registered address.
    // The first element of a walk always gets address 0. One of two cases
    // holds: PAD is 0, so the element is (0,0), or PAD is nonzero and the
    // element is padded. So the start cycle does not use pad_off, which is
    // still being loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q    <= '0;
            plane    <= '0;
            row_step <= '0;
            ox_s     <= '0;
            oy_s     <= '0;
            oy_row   <= '0;
            fy_row   <= '0;
            chan     <= '0;
            adr      <= '0;
            adr_pad  <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (config_en && (state == IDLE)) begin
                cfg_q <= config_data;
            end
            if (start_go) begin
                plane    <= AW'(ix0) * AW'(iy0);
                row_step <= AW'(stride) * AW'(ix0);
            end
            ox_s   <= nxt_ox_s;
            oy_s   <= nxt_oy_s;
            oy_row <= nxt_oy_row;
            fy_row <= nxt_fy_row;
            chan   <= nxt_chan;
            done   <= zero_job || last_hs;
            if (start_go) begin
                adr     <= '0;
                adr_pad <= pad_calc;
            end else if (last_hs) begin
                adr     <= '0;
                adr_pad <= 1'b0;
            end else if (adv) begin
                adr     <= pad_calc ? '0 : adr_calc;
                adr_pad <= pad_calc;
            end
        end
    end

endmodule

// File: tb/tb_ifmap_tile_radr_gen.sv
// Self-checking bench for ifmap_tile_radr_gen.
// A reference model enumerates the loop nest with plain arithmetic. Each
// handshaken address is compared against the model. A table of directed
// jobs also checks count, first, last and sum. Hand-written sequences cover
// zero bounds, reset during a walk and padding.
// With IFMAP_RADR_PAD_EN defined, the model and the padding test honour PAD.
module tb_ifmap_tile_radr_gen;

    import ifmap_radr_pkg::*;

    localparam int AW = 8;
    localparam int CW = CFG_WIDTH_DEFAULT;
`ifdef IFMAP_RADR_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         config_en = 1'b0;
    logic [CW*NUM_CFG_FIELDS-1:0] config_data = '0;
    logic                         start = 1'b0;
    logic                         adr_ready = 1'b0;
    logic                         adr_valid;
    logic [AW-1:0]                adr;
    logic                         adr_pad;
    logic                         busy;
    logic                         done;

    int vectors = 0;
    int miscompares = 0;
    int exp_adr[$];
    bit exp_pad[$];
    int obs_adr[$];
    bit obs_pad[$];

    typedef struct {
        cfg_t cfg;
        int   mode;
        int   n;
        int   first;
        int   last;
        int   sum;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    ifmap_tile_radr_gen #(
        .BANK_ADDR_WIDTH(AW),
        .CFG_WIDTH(CW),
        .NUM_CFG_FIELDS(NUM_CFG_FIELDS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .config_en(config_en),
        .config_data(config_data),
        .start(start),
        .adr_valid(adr_valid),
        .adr_ready(adr_ready),
        .adr(adr),
        .adr_pad(adr_pad),
        .busy(busy),
        .done(done)
    );

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic cfg_t mkCfg(input int ox0, input int oy0, input int fx, input int fy,
                                   input int stride, input int ix0, input int iy0,
                                   input int ic1, input int pad);
        cfg_t c;
        c.ox0 = CW'(ox0);  c.oy0 = CW'(oy0);  c.fx = CW'(fx);   c.fy = CW'(fy);
        c.stride = CW'(stride); c.ix0 = CW'(ix0); c.iy0 = CW'(iy0);
        c.ic1 = CW'(ic1);  c.pad = CW'(pad);
        return c;
    endfunction

    // Walk the loop nest directly and list every expected (address, pad) pair.
    function automatic void buildModel(input cfg_t c);
        int p, ix, iy, a;
        bit padded;
        exp_adr.delete();
        exp_pad.delete();
        p = PAD_EN ? int'(c.pad) : 0;
        for (int ic = 0; ic < int'(c.ic1); ic++)
            for (int ky = 0; ky < int'(c.fy); ky++)
                for (int kx = 0; kx < int'(c.fx); kx++)
                    for (int y = 0; y < int'(c.oy0); y++)
                        for (int x = 0; x < int'(c.ox0); x++) begin
                            ix = x * int'(c.stride) + kx - p;
                            iy = y * int'(c.stride) + ky - p;
                            padded = PAD_EN && (ix < 0 || ix >= int'(c.ix0) ||
                                                iy < 0 || iy >= int'(c.iy0));
                            a = ic * int'(c.ix0) * int'(c.iy0) + iy * int'(c.ix0) + ix;
                            exp_adr.push_back(padded ? 0 : (a & ((1 << AW) - 1)));
                            exp_pad.push_back(padded);
                        end
    endfunction

    task automatic loadConfig(input cfg_t c);
        @(negedge clk);
        config_en = 1'b1;
        config_data = c;
        @(negedge clk);
        config_en = 1'b0;
    endtask

    // Run one job. Ready modes: 0 = always, 1 = pattern 1,0,0, 2 = random.
    task automatic applyStimulus(input cfg_t c, input int mode, input string tag);
        int idx, done_cnt, tail;
        bit stall, after_last, rdy, held_pad;
        int held_adr;
        idx = 0; done_cnt = 0; tail = 0;
        stall = 1'b0; after_last = 1'b0; held_adr = 0; held_pad = 1'b0;
        buildModel(c);
        obs_adr.delete();
        obs_pad.delete();
        loadConfig(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, " first_valid"}, int'(adr_valid), 1);
        checkOutput({tag, " first_busy"}, int'(busy), 1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (done) done_cnt++;
            if (after_last) begin
                checkOutput({tag, " done_pulse"}, int'(done), 1);
                checkOutput({tag, " done_valid"}, int'(adr_valid), 0);
                checkOutput({tag, " done_busy"}, int'(busy), 0);
                after_last = 1'b0;
                tail = 1;
            end
            if (stall) begin
                checkOutput($sformatf("%s hold_valid[%0d]", tag, idx), int'(adr_valid), 1);
                checkOutput($sformatf("%s hold_adr[%0d]", tag, idx), int'(adr), held_adr);
                checkOutput($sformatf("%s hold_pad[%0d]", tag, idx), int'(adr_pad), int'(held_pad));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            adr_ready = rdy;
            stall = adr_valid && !rdy;
            held_adr = int'(adr);
            held_pad = adr_pad;
            if (adr_valid && rdy) begin
                if (idx < exp_adr.size()) begin
                    checkOutput($sformatf("%s adr[%0d]", tag, idx), int'(adr), exp_adr[idx]);
                    checkOutput($sformatf("%s pad[%0d]", tag, idx), int'(adr_pad), int'(exp_pad[idx]));
                end else begin
                    checkOutput($sformatf("%s extra_handshake", tag), idx, exp_adr.size() - 1);
                end
                obs_adr.push_back(int'(adr));
                obs_pad.push_back(adr_pad);
                idx++;
                if (idx == exp_adr.size()) after_last = 1'b1;
            end
            if (tail > 0) tail++;
            if (tail > 4) break;
            @(negedge clk);
        end
        adr_ready = 1'b0;
        checkOutput({tag, " handshake_count"}, idx, exp_adr.size());
        checkOutput({tag, " done_count"}, done_cnt, 1);
    endtask

    initial begin
        int hs, sum;
        $display("[TB] start");
        vecs[0] = '{mkCfg(2, 2, 2, 2, 1, 3, 3, 1, 0), 0, 16, 0, 8, 64};
        vecs[1] = '{mkCfg(2, 2, 2, 2, 1, 3, 4, 2, 0), 0, 32, 0, 20, 320};
        vecs[2] = '{mkCfg(2, 1, 3, 1, 2, 5, 1, 1, 0), 0, 6, 0, 4, 12};
        vecs[3] = '{mkCfg(2, 2, 2, 2, 1, 3, 3, 1, 0), 1, 16, 0, 8, 64};

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset adr_valid", int'(adr_valid), 0);
        checkOutput("reset adr", int'(adr), 0);
        checkOutput("reset adr_pad", int'(adr_pad), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        rst_n = 1'b1;

        // Directed table
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].cfg, vecs[v].mode, $sformatf("vec%0d", v));
            sum = 0;
            foreach (obs_adr[k]) sum += obs_adr[k];
            checkOutput($sformatf("vec%0d count", v), obs_adr.size(), vecs[v].n);
            if (obs_adr.size() > 0) begin
                checkOutput($sformatf("vec%0d first", v), obs_adr[0], vecs[v].first);
                checkOutput($sformatf("vec%0d last", v), obs_adr[obs_adr.size()-1], vecs[v].last);
            end
            checkOutput($sformatf("vec%0d sum", v), sum, vecs[v].sum);
        end

        // Zero loop bound: no addresses, done next cycle
        loadConfig(mkCfg(2, 2, 0, 2, 1, 3, 3, 1, 0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("zero adr_valid", int'(adr_valid), 0);
        checkOutput("zero done", int'(done), 1);
        checkOutput("zero busy", int'(busy), 0);
        @(negedge clk);
        checkOutput("zero done_once", int'(done), 0);
        checkOutput("zero adr_valid_after", int'(adr_valid), 0);

        // Reset in the middle of a walk
        loadConfig(vecs[0].cfg);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        adr_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 50 && hs < 5; i++) begin
            if (adr_valid && adr_ready) hs++;
            @(negedge clk);
        end
        adr_ready = 1'b0;
        checkOutput("mid handshakes", hs, 5);
        checkOutput("mid adr", int'(adr), 2);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset adr_valid", int'(adr_valid), 0);
        checkOutput("midreset adr", int'(adr), 0);
        checkOutput("midreset busy", int'(busy), 0);
        checkOutput("midreset done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postreset done", int'(done), 0);
        applyStimulus(vecs[0].cfg, 0, "restart");
        if (obs_adr.size() > 0) checkOutput("restart first", obs_adr[0], 0);

`ifdef IFMAP_RADR_PAD_EN
        // Padding: element (ox=1, oy=1, fx=0, fy=0) is the first one inside the ifmap
        applyStimulus(mkCfg(2, 2, 3, 3, 1, 2, 2, 1, 1), 0, "pad");
        if (obs_pad.size() >= 4) begin
            checkOutput("pad e0", int'(obs_pad[0]), 1);
            checkOutput("pad e1", int'(obs_pad[1]), 1);
            checkOutput("pad e2", int'(obs_pad[2]), 1);
            checkOutput("pad e3", int'(obs_pad[3]), 0);
            checkOutput("pad e3 adr", obs_adr[3], 0);
        end else begin
            checkOutput("pad element_count", obs_pad.size(), 4);
        end
`endif

        // Randomized jobs against the model with random backpressure
        for (int r = 0; r < 20; r++) begin
            applyStimulus(mkCfg($urandom_range(1, 3), $urandom_range(1, 3),
                                $urandom_range(1, 3), $urandom_range(1, 3),
                                $urandom_range(0, 3), $urandom_range(1, 6),
                                $urandom_range(1, 6), $urandom_range(1, 3),
                                $urandom_range(0, 2)),
                          2, $sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
